// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers a round-robin word stream into per-channel
// output registers, recovering frame alignment from a sync marker on channel 0.
module tdm_demux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      valid_in,
    input  logic                      sync_in,
    input  logic                      clr_err,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]       valid_out,
    output logic                      frame_done,
    output logic                      sync_err,
    output logic                      err_flag,
    output logic                      locked
);

    localparam int unsigned CNT_W = $clog2(CHANNELS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(CHANNELS - 1);

    typedef enum logic [0:0] {StHunt, StRun} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          ch_cnt_q, ch_cnt_d;
    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [CHANNELS-1:0]       valid_out_q, valid_out_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sync_err_q, sync_err_d;
    logic                      err_flag_q, err_flag_d;

    logic                      wr_en;
    logic [CNT_W-1:0]          wr_slot;

    // Next-state decode: alignment tracking, slot selection and error detection.
    // A write to the last slot can only be reached by walking 0..CHANNELS-1 in
    // order after a sync, so it alone marks a complete frame.
    always_comb begin
        state_d      = state_q;
        ch_cnt_d     = ch_cnt_q;
        wr_en        = 1'b0;
        wr_slot      = ch_cnt_q;
        sync_err_d   = 1'b0;
        frame_done_d = 1'b0;

        if (valid_in) begin
            unique case (state_q)
                StHunt: begin
                    // Words without sync are dropped silently while hunting.
                    if (sync_in) begin
                        wr_en    = 1'b1;
                        wr_slot  = '0;
                        ch_cnt_d = CNT_W'(1);
                        state_d  = StRun;
                    end
                end
                StRun: begin
                    if (sync_in) begin
                        // Early sync truncates the current frame but stays aligned.
                        sync_err_d = (ch_cnt_q != '0);
                        wr_en      = 1'b1;
                        wr_slot    = '0;
                        ch_cnt_d   = CNT_W'(1);
                    end else if (ch_cnt_q != '0) begin
                        wr_en        = 1'b1;
                        wr_slot      = ch_cnt_q;
                        ch_cnt_d     = ch_cnt_q + CNT_W'(1);
                        frame_done_d = (ch_cnt_q == LAST_SLOT);
                    end else begin
                        // Missing sync: frame is too long, alignment lost.
                        sync_err_d = 1'b1;
                        ch_cnt_d   = '0;
                        state_d    = StHunt;
                    end
                end
                default: begin
                    state_d  = StHunt;
                    ch_cnt_d = '0;
                end
            endcase
        end
    end

    // One-hot write strobe for the selected slot.
    always_comb begin
        valid_out_d = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            valid_out_d[k] = wr_en && (wr_slot == CNT_W'(k));
        end
    end

    // Sticky error: a new error wins over a simultaneous clear.
    always_comb begin
        err_flag_d = err_flag_q;
        if (sync_err_d) begin
            err_flag_d = 1'b1;
        end else if (clr_err) begin
            err_flag_d = 1'b0;
        end
    end

    // State, counter and pulse/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StHunt;
            ch_cnt_q     <= '0;
            valid_out_q  <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_cnt_q     <= ch_cnt_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            err_flag_q   <= err_flag_d;
        end
    end

    // Per-channel data registers; unwritten slices hold their last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                if (valid_out_d[k]) begin
                    data_q[k*WIDTH +: WIDTH] <= data_in;
                end
            end
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign err_flag   = err_flag_q;
    assign locked     = (state_q == StRun);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed, table-driven bench for tdm_demux (WIDTH=8, CHANNELS=4).
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        sync_in;
    logic        clr_err;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        frame_done;
    logic        sync_err;
    logic        err_flag;
    logic        locked;

    int checks;
    int errors;

    tdm_demux #(
        .WIDTH    (8),
        .CHANNELS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .sync_in    (sync_in),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .err_flag   (err_flag),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        sync;
        logic        clr;
        logic [7:0]  data;
        logic [3:0]  vo;
        logic        fd;
        logic        se;
        logic        ef;
        logic        lk;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic add(input logic v, input logic s, input logic c, input logic [7:0] d,
                       input logic [3:0] vo, input logic fd, input logic se, input logic ef,
                       input logic lk, input logic [31:0] dout);
        vec_t x;
        x.valid = v; x.sync = s; x.clr = c; x.data = d;
        x.vo = vo; x.fd = fd; x.se = se; x.ef = ef; x.lk = lk; x.dout = dout;
        vecs.push_back(x);
    endtask

    // Drive one vector on the falling edge, sample just after the next rising edge.
    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        valid_in = x.valid;
        sync_in  = x.sync;
        clr_err  = x.clr;
        data_in  = x.data;
        @(posedge clk);
        #1;
        check({tag, " valid_out"},  32'(valid_out),  32'(x.vo));
        check({tag, " frame_done"}, 32'(frame_done), 32'(x.fd));
        check({tag, " sync_err"},   32'(sync_err),   32'(x.se));
        check({tag, " err_flag"},   32'(err_flag),   32'(x.ef));
        check({tag, " locked"},     32'(locked),     32'(x.lk));
        check({tag, " data_out"},   data_out,        x.dout);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid_out"},  32'(valid_out),  32'h0);
        check({tag, " frame_done"}, 32'(frame_done), 32'h0);
        check({tag, " sync_err"},   32'(sync_err),   32'h0);
        check({tag, " err_flag"},   32'(err_flag),   32'h0);
        check({tag, " locked"},     32'(locked),     32'h0);
        check({tag, " data_out"},   data_out,        32'h0);
    endtask

    initial begin
        vec_t x;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sync_in  = 1'b0;
        clr_err  = 1'b0;
        data_in  = 8'h00;

        //  v  s  c  data   vo       fd se ef lk dout
        // Full frame, back to back.
        add(1, 1, 0, 8'h11, 4'b0001, 0, 0, 0, 1, 32'h00000011);
        add(1, 0, 0, 8'h22, 4'b0010, 0, 0, 0, 1, 32'h00002211);
        add(1, 0, 0, 8'h33, 4'b0100, 0, 0, 0, 1, 32'h00332211);
        add(1, 0, 0, 8'h44, 4'b1000, 1, 0, 0, 1, 32'h44332211);
        // Missing sync: error, word dropped, lock lost.
        add(1, 0, 0, 8'h99, 4'b0000, 0, 1, 1, 0, 32'h44332211);
        // Hunting: unsynced words ignored.
        add(1, 0, 0, 8'hAA, 4'b0000, 0, 0, 1, 0, 32'h44332211);
        add(1, 0, 0, 8'hBB, 4'b0000, 0, 0, 1, 0, 32'h44332211);
        add(1, 1, 0, 8'h01, 4'b0001, 0, 0, 1, 1, 32'h44332201);
        add(1, 0, 0, 8'h02, 4'b0010, 0, 0, 1, 1, 32'h44330201);
        add(1, 0, 0, 8'h03, 4'b0100, 0, 0, 1, 1, 32'h44030201);
        add(1, 0, 0, 8'h04, 4'b1000, 1, 0, 1, 1, 32'h04030201);
        // Early sync truncates a frame.
        add(1, 1, 0, 8'h10, 4'b0001, 0, 0, 1, 1, 32'h04030210);
        add(1, 0, 0, 8'h20, 4'b0010, 0, 0, 1, 1, 32'h04032010);
        add(1, 1, 0, 8'h30, 4'b0001, 0, 1, 1, 1, 32'h04032030);
        add(1, 0, 0, 8'h40, 4'b0010, 0, 0, 1, 1, 32'h04034030);
        add(1, 0, 0, 8'h50, 4'b0100, 0, 0, 1, 1, 32'h04504030);
        add(1, 0, 0, 8'h60, 4'b1000, 1, 0, 1, 1, 32'h60504030);
        add(0, 0, 0, 8'h00, 4'b0000, 0, 0, 1, 1, 32'h60504030);
        add(0, 0, 1, 8'h00, 4'b0000, 0, 0, 0, 1, 32'h60504030);
        // Gapped frame; sync and data during gaps must be ignored.
        add(1, 1, 0, 8'h11, 4'b0001, 0, 0, 0, 1, 32'h60504011);
        add(0, 1, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60504011);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60504011);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60504011);
        add(1, 0, 0, 8'h22, 4'b0010, 0, 0, 0, 1, 32'h60502211);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60502211);
        add(0, 1, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60502211);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60502211);
        add(1, 0, 0, 8'h33, 4'b0100, 0, 0, 0, 1, 32'h60332211);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60332211);
        add(0, 0, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60332211);
        add(0, 1, 0, 8'hEE, 4'b0000, 0, 0, 0, 1, 32'h60332211);
        add(1, 0, 0, 8'h44, 4'b1000, 1, 0, 0, 1, 32'h44332211);
        // Error and clear in the same cycle: set wins.
        add(1, 1, 0, 8'h5A, 4'b0001, 0, 0, 0, 1, 32'h4433225A);
        add(1, 1, 1, 8'h6B, 4'b0001, 0, 1, 1, 1, 32'h4433226B);
        add(0, 0, 1, 8'h00, 4'b0000, 0, 0, 0, 1, 32'h4433226B);
        add(1, 0, 0, 8'h21, 4'b0010, 0, 0, 0, 1, 32'h4433216B);

        // Reset state.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Mid-frame asynchronous reset, then an unsynced word must be ignored.
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        @(negedge clk);
        rst_n = 1'b1;

        x = '{valid: 1, sync: 0, clr: 0, data: 8'h55, vo: 4'b0000, fd: 0, se: 0, ef: 0, lk: 0,
              dout: 32'h00000000};
        apply(x, "post_reset_nosync");
        x = '{valid: 1, sync: 1, clr: 0, data: 8'h66, vo: 4'b0001, fd: 0, se: 0, ef: 0, lk: 1,
              dout: 32'h00000066};
        apply(x, "post_reset_sync");

        @(negedge clk);
        valid_in = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: takes the single word stream produced by the channel multiplexer and steers each word, in round-robin order, to its own output register. It sits on the receive side of the mux path. It recovers frame alignment from a sync marker on the first word of each frame. It also flags and recovers from framing errors.

## Interface
- WIDTH, 8, bits per data word (1..32)
- CHANNELS, 4, channels per frame (power of 2, 2..16)

- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Data_in  in  WIDTH  muxed data word
- Valid_in  in  1  Data_in valid this cycle
- Sync_in  in  1  qualifies Data_in as channel 0 (first word of a frame); ignored when Valid_in=0
- Clr_err  in  1  clears Err_flag
- Data_out  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; each slice holds its last written word
- Valid_out  out  CHANNELS  one-cycle strobe per channel; slice k updated
- Frame_done  out  1  one-cycle pulse; last channel of a complete, in-order frame written
- Sync_err  out  1  one-cycle pulse on a framing error
- Err_flag  out  1  sticky error, set by Sync_err
- Locked  out  1  high in RUN state

## Operation
- State machine: HUNT (not aligned) and RUN (aligned). Channel counter Ch_cnt, log2(CHANNELS) bits, wraps CHANNELS-1 -> 0.
- HUNT:
  - Valid_in=1, Sync_in=1: write slot 0, Ch_cnt=1, go to RUN.
  - Valid_in=1, Sync_in=0: word discarded, no strobe, no error.
- RUN, Valid_in=1:
  - Sync_in=0 and Ch_cnt!=0: write slot Ch_cnt, Ch_cnt+1.
  - Sync_in=1 and Ch_cnt==0: normal frame start; write slot 0, Ch_cnt=1.
  - Sync_in=1 and Ch_cnt!=0 (early sync, short frame): pulse Sync_err; write slot 0; Ch_cnt=1; stay in RUN. No Frame_done for the truncated frame.
  - Sync_in=0 and Ch_cnt==0 (missing sync, long frame): pulse Sync_err; word discarded; go to HUNT.
- Writing slot CHANNELS-1 wraps Ch_cnt to 0. Frame_done pulses only if slots 0..CHANNELS-1 of the current frame were all written in order since the last sync.
- Valid_in=0: no state change, no strobes. Gaps of any length inside a frame are legal.
- Err_flag: set on any Sync_err, cleared by Clr_err. If both occur in the same cycle, set wins.
- Unwritten slots keep their previous contents; there is no clearing on error or resync.

## Timing
- All outputs are registered.
- Latency: a word sampled at edge N appears on its Data_out slice after edge N. Its Valid_out bit, Frame_done and Sync_err are high for exactly the cycle following edge N.
- Frame_done is coincident with Valid_out[CHANNELS-1].
- Throughput: one word per cycle, sustained, with no back-pressure.
- Reset (Rst_n low, asynchronous):
  - Data_out=0, Valid_out=0, Frame_done=0, Sync_err=0, Err_flag=0, Locked=0.
  - State HUNT, Ch_cnt=0.
  - Reset mid-frame discards the partial frame. The first word after release must carry Sync_in to be accepted.
- Locked follows the state register: it rises the cycle after the accepting sync word and falls the cycle after a missing-sync error.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4.

1. Reset, then back-to-back words 0x11(sync), 0x22, 0x33, 0x44. Required:
   - Valid_out strobes 0001, 0010, 0100, 1000 on consecutive cycles.
   - Data_out=0x44332211.
   - Frame_done pulses with the last strobe.
   - Locked=1.
2. While in HUNT, send 0xAA and 0xBB without sync, then a full frame 0x01(sync)..0x04. Required:
   - No strobes or errors for 0xAA/0xBB.
   - Data_out=0x04030201 and one Frame_done.
3. Send 0x10(sync), 0x20, then 0x30(sync), 0x40, 0x50, 0x60. Required:
   - Sync_err pulses once, on the 0x30 word.
   - No Frame_done for the short frame; Frame_done on 0x60.
   - Data_out=0x60504030.
   - Err_flag stays 1 until Clr_err.
4. Send a full frame, then 0x99 without sync. Required:
   - Sync_err pulses; 0x99 not written.
   - Locked falls; Data_out unchanged.
5. Full frame with Valid_in deasserted for 3 cycles between every word. Required: identical result to scenario 1, and no strobes during the gaps.
6. Assert Rst_n low after the 2nd word of a frame, then release and send 0x55 without sync. Required:
   - All outputs 0 during reset.
   - 0x55 ignored; Locked stays 0.
